udp_panel_burst_writer: RTL and testbench
=========================================

Name: udp_panel_burst_writer

Overview:
Parametrised successor to the single-pixel UDP panel writer. Receives a byte-per-beat UDP payload stream and decodes a 2-byte big-endian start address followed by packed RGB888 pixels. Issues one panel-RAM write per pixel with auto-incrementing address, a panel-select mask from the destination port, and backpressure from the panel side. Also supports an optional frame-swap pulse, and drops packets that carry errors. Sits between the LiteEth UDP source port and the panel controller write port.

Parameters:
PORT_MSB, 8'h66, required value of udp_source_dst_port[15:8] for a packet to be accepted
NUM_PANELS, 6, width of ctrl_en; mask taken from dst_port[NUM_PANELS-1:0] (1..7)
ADDR_W, 16, panel address width (1..16); start address uses the low ADDR_W bits of the header
COLOR_W, 6, bits per channel written (1..8); each channel takes byte[7:8-COLOR_W]
SWAP_BIT, 7, dst_port bit that requests a frame swap at packet end (must be >= NUM_PANELS)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
udp_source_valid  in  1  payload beat valid
udp_source_last  in  1  final beat of packet
udp_source_ready  out  1  beat accepted when valid&&ready
udp_source_dst_port  in  16  UDP destination port
udp_source_data  in  32  payload; only [7:0] used
udp_source_error  in  4  nonzero = corrupt beat
ctrl_en  out  NUM_PANELS  per-panel write enable, held until ctrl_ready
ctrl_ready  in  1  panel side accepts the pending write
ctrl_wr  out  4  constant 4'b0111 (RGB lanes)
ctrl_addr  out  ADDR_W  pixel address
ctrl_wdat  out  3*COLOR_W  {R,G,B}
frame_swap  out  1  one-cycle pulse at the end of a clean packet with the swap bit set
led_reg  out  1  1 in IDLE, 0 otherwise

Behaviour:
- Reset (async, reset_n=0): state=IDLE; ctrl_en=0, ctrl_addr=0, ctrl_wdat=0, frame_swap=0, led_reg=0, address/byte counters=0, pending=0.
- udp_source_ready = !pending || ctrl_ready (combinational). It is 0 while reset_n=0.
- Beats are processed only when valid&&ready.
- IDLE:
  - Matching port and error==0: latch mask and swap request; addr_hi<=data.
  - If last: runt; return to IDLE, no write, no swap.
  - Else go to ADDR_LO.
  - Non-matching port, or error!=0: go to DROP unless last.
- ADDR_LO: addr<={addr_hi,data} truncated to ADDR_W; byte_idx=0.
  - If last: go to IDLE and emit the swap if requested.
  - Else go to PIXEL.
- PIXEL:
  - Bytes 0,1,2 = R,G,B.
  - On byte 2: pending=1, ctrl_en=mask, ctrl_addr=addr, ctrl_wdat={R,G,B} from the registered R,G and the live B. Then addr=addr+1, wrapping modulo 2^ADDR_W; byte_idx=0.
  - Write latency: 1 cycle after the 3rd byte is accepted.
  - last on byte 2: the write is issued and the state returns to IDLE.
  - last on byte 0/1: the partial pixel is discarded and the state returns to IDLE.
  - Swap still fires in both cases if requested.
- DROP: consume beats until last, then go to IDLE. No writes, no swap.
- Error beat in ADDR_LO/PIXEL: go to DROP, or to IDLE if last. Writes already issued stand; no further writes; swap suppressed.
- Pending write: ctrl_en/addr/wdat held stable until a cycle with ctrl_ready=1; ctrl_en drops to 0 the following cycle unless a new pixel completes in the same cycle (back-to-back allowed).
- Mask=0: pixels are still parsed and the address still advances, but ctrl_en stays 0 and pending is not set.
- frame_swap: asserted the cycle after the terminating beat is accepted.
- Reset mid-packet: everything is cleared; the next beats are treated as a new packet (upstream is responsible for framing).

Optional Feature:
UDP_PANEL_WRITER_STATS_EN:
- Defined: adds outputs stat_pkts (16b, clean packets completed), stat_drops (16b, foreign/error/runt packets) and stat_partial (16b, packets ending mid-pixel). Counters saturate at 16'hFFFF and clear on reset.
- Undefined: none of these ports or counters exist; behaviour is otherwise identical.

Test Plan:
- Port 0x6603, payload 00 10 FF 80 04 (COLOR_W=6) -> one write: ctrl_en=6'h03, addr=0x0010, wdat={6'h3F,6'h20,6'h01}; ctrl_wr=0111.
- Port 0x6601, header FF FF + 2 pixels, ADDR_W=16 -> writes at 0xFFFF then 0x0000 (wrap).
- ctrl_ready held 0 for 5 cycles during a 3-pixel burst -> udp_source_ready low while pending; all 3 writes appear in order, none lost or duplicated.
- Port 0x6681, 8-byte payload (header + 2 pixels), 1st pixel clean, error!=0 on the 7th byte -> exactly 1 write, no frame_swap, state reaches IDLE on last.
- Port 0x1234 packet, then port 0x6680 header-only packet -> no writes; frame_swap pulses once, 1 cycle after the 2nd packet's last beat.
- reset_n asserted mid-pixel, then a clean 1-pixel packet -> all outputs at reset values during reset; only the new packet's pixel is written.

Source files
------------

// File: rtl/udp_panel_burst_writer_if.sv
// Interface bundle for udp_panel_burst_writer: UDP payload source port and panel write port.
// master = writer view, slave = environment (UDP source + panel controller) view.
interface udp_panel_burst_writer_if #(
    parameter int NUM_PANELS = 6,
    parameter int ADDR_W     = 16,
    parameter int COLOR_W    = 6
);
    logic                   udp_source_valid;
    logic                   udp_source_last;
    logic                   udp_source_ready;
    logic [15:0]            udp_source_dst_port;
    logic [31:0]            udp_source_data;
    logic [3:0]             udp_source_error;
    logic [NUM_PANELS-1:0]  ctrl_en;
    logic                   ctrl_ready;
    logic [3:0]             ctrl_wr;
    logic [ADDR_W-1:0]      ctrl_addr;
    logic [3*COLOR_W-1:0]   ctrl_wdat;

    modport master (
        input  udp_source_valid, udp_source_last, udp_source_dst_port,
        input  udp_source_data, udp_source_error, ctrl_ready,
        output udp_source_ready, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat
    );

    modport slave (
        output udp_source_valid, udp_source_last, udp_source_dst_port,
        output udp_source_data, udp_source_error, ctrl_ready,
        input  udp_source_ready, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat
    );
endinterface

// File: rtl/udp_panel_burst_writer.sv
// UDP payload -> panel RAM burst writer: 2-byte start address, then RGB888 pixels, one write per pixel.
// Optional packet statistics outputs enabled by defining UDP_PANEL_WRITER_STATS_EN.
module udp_panel_burst_writer #(
    parameter logic [7:0] PORT_MSB   = 8'h66,
    parameter int         NUM_PANELS = 6,
    parameter int         ADDR_W     = 16,
    parameter int         COLOR_W    = 6,
    parameter int         SWAP_BIT   = 7
) (
    input  logic                      clock,
    input  logic                      reset_n,
    udp_panel_burst_writer_if.master  bus,
    output logic                      frame_swap,
    output logic                      led_reg
`ifdef UDP_PANEL_WRITER_STATS_EN
    ,
    output logic [15:0]               stat_pkts,
    output logic [15:0]               stat_drops,
    output logic [15:0]               stat_partial
`endif
);

    typedef enum logic [1:0] {IDLE, ADDR_LO, PIXEL, DROP} state_t;

    state_t                 state_q, state_d;
    logic [NUM_PANELS-1:0]  mask_q, mask_d;
    logic                   swap_req_q, swap_req_d;
    logic [7:0]             addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [COLOR_W-1:0]     r_q, r_d, g_q, g_d;
    logic                   pending_q, pending_d;
    logic [NUM_PANELS-1:0]  ctrl_en_q, ctrl_en_d;
    logic [ADDR_W-1:0]      ctrl_addr_q, ctrl_addr_d;
    logic [3*COLOR_W-1:0]   ctrl_wdat_q, ctrl_wdat_d;
    logic                   frame_swap_q, frame_swap_d;
    logic                   led_q, led_d;

    logic                   ready;
    logic                   accept;
    logic                   port_ok;
    logic                   beat_err;
    logic [COLOR_W-1:0]     chan;
    logic [15:0]            hdr;
    logic                   end_clean, end_partial, end_drop;
    logic                   unused_bits;

    assign ready    = reset_n && (!pending_q || bus.ctrl_ready);
    assign accept   = bus.udp_source_valid && ready;
    assign port_ok  = (bus.udp_source_dst_port[15:8] == PORT_MSB);
    assign beat_err = (bus.udp_source_error != 4'd0);
    assign chan     = bus.udp_source_data[7 -: COLOR_W];
    assign hdr      = {addr_hi_q, bus.udp_source_data[7:0]};

    assign unused_bits = ^{bus.udp_source_data, bus.udp_source_dst_port};

    assign bus.udp_source_ready = ready;
    assign bus.ctrl_en          = ctrl_en_q;
    assign bus.ctrl_wr          = 4'b0111;
    assign bus.ctrl_addr        = ctrl_addr_q;
    assign bus.ctrl_wdat        = ctrl_wdat_q;
    assign frame_swap           = frame_swap_q;
    assign led_reg              = led_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            swap_req_q   <= 1'b0;
            addr_hi_q    <= '0;
            addr_q       <= '0;
            byte_idx_q   <= '0;
            r_q          <= '0;
            g_q          <= '0;
            pending_q    <= 1'b0;
            ctrl_en_q    <= '0;
            ctrl_addr_q  <= '0;
            ctrl_wdat_q  <= '0;
            frame_swap_q <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            swap_req_q   <= swap_req_d;
            addr_hi_q    <= addr_hi_d;
            addr_q       <= addr_d;
            byte_idx_q   <= byte_idx_d;
            r_q          <= r_d;
            g_q          <= g_d;
            pending_q    <= pending_d;
            ctrl_en_q    <= ctrl_en_d;
            ctrl_addr_q  <= ctrl_addr_d;
            ctrl_wdat_q  <= ctrl_wdat_d;
            frame_swap_q <= frame_swap_d;
            led_q        <= led_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        swap_req_d   = swap_req_q;
        addr_hi_d    = addr_hi_q;
        addr_d       = addr_q;
        byte_idx_d   = byte_idx_q;
        r_d          = r_q;
        g_d          = g_q;
        pending_d    = pending_q;
        ctrl_en_d    = ctrl_en_q;
        ctrl_addr_d  = ctrl_addr_q;
        ctrl_wdat_d  = ctrl_wdat_q;
        frame_swap_d = 1'b0;
        end_clean    = 1'b0;
        end_partial  = 1'b0;
        end_drop     = 1'b0;

        // Retire the pending write first; a pixel completing this cycle overrides it.
        if (pending_q && bus.ctrl_ready) begin
            pending_d = 1'b0;
            ctrl_en_d = '0;
        end

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (port_ok && !beat_err) begin
                        mask_d     = bus.udp_source_dst_port[NUM_PANELS-1:0];
                        swap_req_d = bus.udp_source_dst_port[SWAP_BIT];
                        addr_hi_d  = bus.udp_source_data[7:0];
                        if (bus.udp_source_last) end_drop = 1'b1;
                        else                     state_d  = ADDR_LO;
                    end else begin
                        end_drop = 1'b1;
                        if (!bus.udp_source_last) state_d = DROP;
                    end
                end
                ADDR_LO: begin
                    if (beat_err) begin
                        end_drop = 1'b1;
                        state_d  = bus.udp_source_last ? IDLE : DROP;
                    end else begin
                        addr_d     = hdr[ADDR_W-1:0];
                        byte_idx_d = 2'd0;
                        if (bus.udp_source_last) begin
                            state_d      = IDLE;
                            frame_swap_d = swap_req_q;
                            end_clean    = 1'b1;
                        end else begin
                            state_d = PIXEL;
                        end
                    end
                end
                PIXEL: begin
                    if (beat_err) begin
                        end_drop = 1'b1;
                        state_d  = bus.udp_source_last ? IDLE : DROP;
                    end else begin
                        case (byte_idx_q)
                            2'd0: begin
                                r_d        = chan;
                                byte_idx_d = 2'd1;
                            end
                            2'd1: begin
                                g_d        = chan;
                                byte_idx_d = 2'd2;
                            end
                            default: begin
                                byte_idx_d = 2'd0;
                                addr_d     = addr_q + ADDR_W'(1);
                                if (mask_q != '0) begin
                                    pending_d   = 1'b1;
                                    ctrl_en_d   = mask_q;
                                    ctrl_addr_d = addr_q;
                                    ctrl_wdat_d = {r_q, g_q, chan};
                                end
                            end
                        endcase
                        if (bus.udp_source_last) begin
                            state_d      = IDLE;
                            frame_swap_d = swap_req_q;
                            end_clean    = 1'b1;
                            end_partial  = (byte_idx_q != 2'd2);
                        end
                    end
                end
                DROP: begin
                    if (bus.udp_source_last) state_d = IDLE;
                end
            endcase
        end

        led_d = (state_d == IDLE);
    end

`ifdef UDP_PANEL_WRITER_STATS_EN
    logic [15:0] pkts_q, drops_q, partial_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pkts_q    <= '0;
            drops_q   <= '0;
            partial_q <= '0;
        end else begin
            if (end_clean)   pkts_q    <= sat_inc(pkts_q);
            if (end_drop)    drops_q   <= sat_inc(drops_q);
            if (end_partial) partial_q <= sat_inc(partial_q);
        end
    end

    assign stat_pkts    = pkts_q;
    assign stat_drops   = drops_q;
    assign stat_partial = partial_q;
`else
    logic unused_stats;
    assign unused_stats = end_clean ^ end_partial ^ end_drop;
`endif

endmodule

// File: tb/tb_udp_panel_burst_writer.sv
// Directed testbench for udp_panel_burst_writer with default parameters (6 panels, 16-bit address, 6-bit colour).
module tb_udp_panel_burst_writer;

    typedef struct packed {
        logic [5:0]  en;
        logic [15:0] addr;
        logic [17:0] wdat;
    } wr_t;

    logic clock;
    logic reset_n;
    logic frame_swap;
    logic led_reg;
    int   errors;
    int   checks;
    int   swap_cnt;
    wr_t  got[$];

    udp_panel_burst_writer_if #(.NUM_PANELS(6), .ADDR_W(16), .COLOR_W(6)) bus ();

    udp_panel_burst_writer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .frame_swap (frame_swap),
        .led_reg    (led_reg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Panel-side handshake and swap-pulse monitors, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset_n && bus.ctrl_en != 6'd0 && bus.ctrl_ready)
            got.push_back('{en: bus.ctrl_en, addr: bus.ctrl_addr, wdat: bus.ctrl_wdat});
        if (frame_swap) swap_cnt++;
    end

    task automatic send_beat(input logic [15:0] port, input logic [7:0] d,
                             input logic l, input logic [3:0] e);
        int n;
        n = 0;
        bus.udp_source_valid    = 1'b1;
        bus.udp_source_dst_port = port;
        bus.udp_source_data     = {24'hA5A5A5, d};
        bus.udp_source_last     = l;
        bus.udp_source_error    = e;
        forever begin
            @(negedge clock);
            if (bus.udp_source_ready) begin
                @(posedge clock);
                #1;
                break;
            end
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout got=ready_low exp=accepted byte=%h", d);
                break;
            end
        end
        bus.udp_source_valid = 1'b0;
        bus.udp_source_last  = 1'b0;
        bus.udp_source_error = 4'd0;
    endtask

    task automatic test_reset();
        reset_n          = 1'b0;
        bus.ctrl_ready   = 1'b1;
        bus.udp_source_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.ctrl_en !== 6'd0) begin errors++; $display("FAIL rst_en got=%h exp=00", bus.ctrl_en); end
        checks++; if (bus.ctrl_addr !== 16'd0) begin errors++; $display("FAIL rst_addr got=%h exp=0000", bus.ctrl_addr); end
        checks++; if (bus.ctrl_wdat !== 18'd0) begin errors++; $display("FAIL rst_wdat got=%h exp=0", bus.ctrl_wdat); end
        checks++; if (frame_swap !== 1'b0) begin errors++; $display("FAIL rst_swap got=%b exp=0", frame_swap); end
        checks++; if (led_reg !== 1'b0) begin errors++; $display("FAIL rst_led got=%b exp=0", led_reg); end
        checks++; if (bus.udp_source_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", bus.udp_source_ready); end
        bus.udp_source_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (led_reg !== 1'b1) begin errors++; $display("FAIL idle_led got=%b exp=1", led_reg); end
        checks++; if (bus.udp_source_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", bus.udp_source_ready); end
    endtask

    task automatic test_single_pixel();
        got.delete();
        send_beat(16'h6603, 8'h00, 1'b0, 4'd0);
        send_beat(16'h6603, 8'h10, 1'b0, 4'd0);
        send_beat(16'h6603, 8'hFF, 1'b0, 4'd0);
        send_beat(16'h6603, 8'h80, 1'b0, 4'd0);
        checks++; if (bus.ctrl_en !== 6'd0) begin errors++; $display("FAIL px_early_en got=%h exp=00", bus.ctrl_en); end
        send_beat(16'h6603, 8'h04, 1'b1, 4'd0);
        checks++; if (bus.ctrl_en !== 6'h03) begin errors++; $display("FAIL px_en got=%h exp=03", bus.ctrl_en); end
        checks++; if (bus.ctrl_addr !== 16'h0010) begin errors++; $display("FAIL px_addr got=%h exp=0010", bus.ctrl_addr); end
        checks++; if (bus.ctrl_wdat !== {6'h3F, 6'h20, 6'h01}) begin errors++; $display("FAIL px_wdat got=%h exp=%h", bus.ctrl_wdat, {6'h3F, 6'h20, 6'h01}); end
        checks++; if (bus.ctrl_wr !== 4'b0111) begin errors++; $display("FAIL px_wr got=%b exp=0111", bus.ctrl_wr); end
        checks++; if (frame_swap !== 1'b0) begin errors++; $display("FAIL px_swap got=%b exp=0", frame_swap); end
        checks++; if (led_reg !== 1'b1) begin errors++; $display("FAIL px_led got=%b exp=1", led_reg); end
        @(posedge clock);
        #1;
        checks++; if (bus.ctrl_en !== 6'd0) begin errors++; $display("FAIL px_en_drop got=%h exp=00", bus.ctrl_en); end
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL px_count got=%0d exp=1", got.size()); end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] bytes [8];
        bytes = '{8'hFF, 8'hFF, 8'h10, 8'h20, 8'h30, 8'hFC, 8'h08, 8'h44};
        got.delete();
        for (int i = 0; i < 8; i++) send_beat(16'h6601, bytes[i], (i == 7), 4'd0);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (got.size() !== 2) begin
            errors++; $display("FAIL wrap_count got=%0d exp=2", got.size());
        end else begin
            checks++; if (got[0].addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr0 got=%h exp=FFFF", got[0].addr); end
            checks++; if (got[1].addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr1 got=%h exp=0000", got[1].addr); end
            checks++; if (got[0].wdat !== {6'h04, 6'h08, 6'h0C}) begin errors++; $display("FAIL wrap_wdat0 got=%h exp=%h", got[0].wdat, {6'h04, 6'h08, 6'h0C}); end
            checks++; if (got[1].wdat !== {6'h3F, 6'h02, 6'h11}) begin errors++; $display("FAIL wrap_wdat1 got=%h exp=%h", got[1].wdat, {6'h3F, 6'h02, 6'h11}); end
            checks++; if (got[1].en !== 6'h01) begin errors++; $display("FAIL wrap_en got=%h exp=01", got[1].en); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] bytes [11];
        logic [17:0] exp_wdat [3];
        bytes    = '{8'h01, 8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24};
        exp_wdat = '{{6'h01, 6'h02, 6'h03}, {6'h04, 6'h05, 6'h06}, {6'h07, 6'h08, 6'h09}};
        got.delete();
        bus.ctrl_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(16'h6602, bytes[i], 1'b0, 4'd0);
        fork
            send_beat(16'h6602, bytes[5], 1'b0, 4'd0);
            begin
                repeat (5) begin
                    @(negedge clock);
                    checks++; if (bus.udp_source_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", bus.udp_source_ready); end
                    checks++; if (bus.ctrl_en !== 6'h02 || bus.ctrl_addr !== 16'h0100) begin errors++; $display("FAIL bp_hold got=%h/%h exp=02/0100", bus.ctrl_en, bus.ctrl_addr); end
                end
                @(posedge clock);
                #1;
                bus.ctrl_ready = 1'b1;
            end
        join
        for (int i = 6; i < 11; i++) send_beat(16'h6602, bytes[i], (i == 10), 4'd0);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (got.size() !== 3) begin
            errors++; $display("FAIL bp_count got=%0d exp=3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got[k].addr !== 16'h0100 + 16'(k) || got[k].wdat !== exp_wdat[k] || got[k].en !== 6'h02) begin
                    errors++;
                    $display("FAIL bp_write%0d got=%h/%h/%h exp=02/%h/%h", k, got[k].en, got[k].addr, got[k].wdat, 16'h0100 + 16'(k), exp_wdat[k]);
                end
            end
        end
    endtask

    task automatic test_error_beat();
        logic [7:0] bytes [8];
        int base;
        bytes = '{8'h00, 8'h20, 8'h40, 8'h80, 8'hC0, 8'h11, 8'h22, 8'h33};
        got.delete();
        base = swap_cnt;
        for (int i = 0; i < 6; i++) send_beat(16'h6681, bytes[i], 1'b0, 4'd0);
        send_beat(16'h6681, bytes[6], 1'b0, 4'h2);
        checks++; if (led_reg !== 1'b0) begin errors++; $display("FAIL err_led_drop got=%b exp=0", led_reg); end
        send_beat(16'h6681, bytes[7], 1'b1, 4'd0);
        checks++; if (led_reg !== 1'b1) begin errors++; $display("FAIL err_led_idle got=%b exp=1", led_reg); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (swap_cnt - base !== 0) begin errors++; $display("FAIL err_swap got=%0d exp=0", swap_cnt - base); end
        checks++;
        if (got.size() !== 1) begin
            errors++; $display("FAIL err_count got=%0d exp=1", got.size());
        end else begin
            checks++;
            if (got[0].addr !== 16'h0020 || got[0].wdat !== {6'h10, 6'h20, 6'h30} || got[0].en !== 6'h01) begin
                errors++; $display("FAIL err_write got=%h/%h/%h exp=01/0020/%h", got[0].en, got[0].addr, got[0].wdat, {6'h10, 6'h20, 6'h30});
            end
        end
    endtask

    task automatic test_swap();
        int base;
        got.delete();
        base = swap_cnt;
        send_beat(16'h1234, 8'hAA, 1'b0, 4'd0);
        send_beat(16'h1234, 8'hBB, 1'b0, 4'd0);
        send_beat(16'h1234, 8'hCC, 1'b1, 4'd0);
        checks++; if (frame_swap !== 1'b0) begin errors++; $display("FAIL swap_foreign got=%b exp=0", frame_swap); end
        send_beat(16'h6680, 8'h00, 1'b0, 4'd0);
        send_beat(16'h6680, 8'h05, 1'b1, 4'd0);
        checks++; if (frame_swap !== 1'b1) begin errors++; $display("FAIL swap_pulse got=%b exp=1", frame_swap); end
        @(posedge clock);
        #1;
        checks++; if (frame_swap !== 1'b0) begin errors++; $display("FAIL swap_width got=%b exp=0", frame_swap); end
        repeat (2) @(posedge clock);
        #1;
        checks++; if (swap_cnt - base !== 1) begin errors++; $display("FAIL swap_count got=%0d exp=1", swap_cnt - base); end
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL swap_writes got=%0d exp=0", got.size()); end
    endtask

    task automatic test_reset_mid_packet();
        int base;
        got.delete();
        base = swap_cnt;
        send_beat(16'h6603, 8'h00, 1'b0, 4'd0);
        send_beat(16'h6603, 8'h40, 1'b0, 4'd0);
        send_beat(16'h6603, 8'hFF, 1'b0, 4'd0);
        send_beat(16'h6603, 8'hFF, 1'b0, 4'd0);
        reset_n = 1'b0;
        #1;
        checks++; if (bus.ctrl_en !== 6'd0 || bus.ctrl_addr !== 16'd0 || bus.ctrl_wdat !== 18'd0) begin errors++; $display("FAIL mid_rst_out got=%h/%h/%h exp=0/0/0", bus.ctrl_en, bus.ctrl_addr, bus.ctrl_wdat); end
        checks++; if (led_reg !== 1'b0 || frame_swap !== 1'b0 || bus.udp_source_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got=led%b/swap%b/rdy%b exp=0/0/0", led_reg, frame_swap, bus.udp_source_ready); end
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send_beat(16'h6601, 8'h00, 1'b0, 4'd0);
        send_beat(16'h6601, 8'h07, 1'b0, 4'd0);
        send_beat(16'h6601, 8'h08, 1'b0, 4'd0);
        send_beat(16'h6601, 8'h0C, 1'b0, 4'd0);
        send_beat(16'h6601, 8'h10, 1'b1, 4'd0);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (got.size() !== 1) begin
            errors++; $display("FAIL mid_count got=%0d exp=1", got.size());
        end else begin
            checks++;
            if (got[0].addr !== 16'h0007 || got[0].wdat !== {6'h02, 6'h03, 6'h04} || got[0].en !== 6'h01) begin
                errors++; $display("FAIL mid_write got=%h/%h/%h exp=01/0007/%h", got[0].en, got[0].addr, got[0].wdat, {6'h02, 6'h03, 6'h04});
            end
        end
        checks++; if (swap_cnt - base !== 0) begin errors++; $display("FAIL mid_swap got=%0d exp=0", swap_cnt - base); end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        swap_cnt = 0;
        reset_n  = 1'b0;
        bus.ctrl_ready          = 1'b1;
        bus.udp_source_valid    = 1'b0;
        bus.udp_source_last     = 1'b0;
        bus.udp_source_dst_port = 16'h0000;
        bus.udp_source_data     = 32'd0;
        bus.udp_source_error    = 4'd0;

        test_reset();
        test_single_pixel();
        test_addr_wrap();
        test_backpressure();
        test_error_beat();
        test_swap();
        test_reset_mid_packet();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
